// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_pkg;

  localparam int unsigned WB_MODE_ROUND_ROBIN = 0;
  localparam int unsigned WB_MODE_FIXED       = 1;

  localparam int unsigned WB_ADDR_WIDTH = 5;
  localparam int unsigned WB_DATA_WIDTH = 32;

  // Queued write payload at the default core widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
    logic                     float;
  } wb_entry_t;

endpackage

// File: rtl/wb_channel_fifo.sv
// Single-channel synchronous FIFO holding queued write-back entries.
module wb_channel_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Multi-channel register-file write-back arbiter: per-channel FIFOs drained one entry
// per cycle onto a registered write port by round-robin or fixed-priority selection.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [CHANNELS-1:0]                           in_enable,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]                in_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                in_data,
  input  logic [CHANNELS-1:0]                           in_float,
  output logic [CHANNELS-1:0]                           in_full,
  output logic [CHANNELS-1:0]                           overflow,
  output logic                                          out_enable,
  output logic [ADDR_WIDTH-1:0]                         out_addr,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic                                          out_float,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel
);

  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned IDX_W   = CH_W + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam bit          FIXED_MODE = (PRIORITY_MODE == WB_MODE_FIXED);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  float;
  } entry_t;

  entry_t              push_entry [CHANNELS];
  logic [ENTRY_W-1:0]  fifo_head  [CHANNELS];
  logic [CNT_W-1:0]    fifo_count [CHANNELS];
  logic [CHANNELS-1:0] push_req;
  logic [CHANNELS-1:0] fifo_full;
  logic [CHANNELS-1:0] fifo_empty;
  logic [CHANNELS-1:0] pop_vec;
  logic [CHANNELS-1:0] drop;

  logic                grant_valid;
  logic [CH_W-1:0]     grant_idx;
  logic [IDX_W-1:0]    cand;
  entry_t              head_sel;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     rr_ptr_next;

  // Unpack requests; integer register 0 writes are discarded before queueing.
  always_comb begin
    push_req = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      push_entry[i].addr  = in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      push_entry[i].data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      push_entry[i].float = in_float[i];
      push_req[i] = in_enable[i] && ((push_entry[i].addr != '0) || in_float[i]);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_fifo
    wb_channel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req[g]),
      .pop       (pop_vec[g]),
      .push_data (push_entry[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .count     (fifo_count[g])
    );
  end

  always_comb begin
    in_full = '0;
    drop    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_full[i] = (fifo_count[i] == CNT_W'(DEPTH));
      drop[i]    = push_req[i] && fifo_full[i] && !pop_vec[i];
    end
  end

  // Pick the first non-empty channel, searching from the pointer (or from 0 in fixed mode).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (FIXED_MODE) begin
        cand = IDX_W'(k);
      end else begin
        cand = IDX_W'(rr_ptr) + IDX_W'(k);
        if (cand >= IDX_W'(CHANNELS)) cand = cand - IDX_W'(CHANNELS);
      end
      if (!grant_valid && !fifo_empty[cand[CH_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    pop_vec  = '0;
    head_sel = entry_t'(fifo_head[grant_idx]);
    if (grant_valid) pop_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (grant_valid && !FIXED_MODE) begin
      rr_ptr_next = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // Output register holds the last write while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      overflow    <= '0;
      out_enable  <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_float   <= 1'b0;
      out_channel <= '0;
    end else begin
      rr_ptr     <= rr_ptr_next;
      overflow   <= overflow | drop;
      out_enable <= grant_valid;
      if (grant_valid) begin
        out_addr    <= head_sel.addr;
        out_data    <= head_sel.data;
        out_float   <= head_sel.float;
        out_channel <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one randomized
// stimulus stream and are checked against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int unsigned CH    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CHW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0]    in_enable;
  logic [CH*AW-1:0] in_addr;
  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]    in_float;

  logic [CH-1:0]  full_o [2];
  logic [CH-1:0]  ovf_o  [2];
  logic           en_o   [2];
  logic [AW-1:0]  addr_o [2];
  logic [DW-1:0]  data_o [2];
  logic           fl_o   [2];
  logic [CHW-1:0] ch_o   [2];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    writeback_arbiter #(
      .CHANNELS      (CH),
      .DEPTH         (DEPTH),
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .PRIORITY_MODE (d)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_enable   (in_enable),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .in_float    (in_float),
      .in_full     (full_o[d]),
      .overflow    (ovf_o[d]),
      .out_enable  (en_o[d]),
      .out_addr    (addr_o[d]),
      .out_data    (data_o[d]),
      .out_float   (fl_o[d]),
      .out_channel (ch_o[d])
    );
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fl;
  } ent_t;

  typedef struct {
    int   cyc;
    ent_t e;
    int   ch;
  } exp_t;

  ent_t          mq [2][CH][$];
  exp_t          sb [2][$];
  int            ptr [2];
  logic [CH-1:0] m_ovf [2];
  ent_t          last [2];
  int            last_ch [2];
  int            ch_out [2][CH];
  int            cyc = 0;
  bit            started = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Reference model: grant from queue heads first, then accept new requests.
  task automatic model_step(input int d);
    int   g;
    int   c;
    ent_t e;
    exp_t x;
    if (reset) begin
      for (int i = 0; i < CH; i++) mq[d][i].delete();
      m_ovf[d]   = '0;
      ptr[d]     = 0;
      last[d]    = '{default: '0};
      last_ch[d] = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < CH; k++) begin
      c = (d == 1) ? k : (ptr[d] + k) % CH;
      if (g < 0 && mq[d][c].size() > 0) g = c;
    end
    if (g >= 0) begin
      x.cyc = cyc;
      x.e   = mq[d][g].pop_front();
      x.ch  = g;
      sb[d].push_back(x);
      if (d == 0) ptr[d] = (g + 1) % CH;
    end
    for (int i = 0; i < CH; i++) begin
      if (in_enable[i]) begin
        e.addr = in_addr[i*AW +: AW];
        e.data = in_data[i*DW +: DW];
        e.fl   = in_float[i];
        if (e.addr != 0 || e.fl) begin
          if (mq[d][i].size() < DEPTH) mq[d][i].push_back(e);
          else m_ovf[d][i] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) started = 1'b1;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Monitor: compare every presented write and every idle cycle against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        logic [CH-1:0] exp_full;
        exp_t x;
        for (int i = 0; i < CH; i++) exp_full[i] = (mq[d][i].size() == DEPTH);
        chk("in_full", d, 64'(full_o[d]), 64'(exp_full));
        chk("overflow", d, 64'(ovf_o[d]), 64'(m_ovf[d]));
        if (en_o[d]) begin
          ch_out[d][ch_o[d]]++;
          if (sb[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write dut%0d cycle %0d: got addr %0h ch %0d expected no write",
                     d, cyc, addr_o[d], ch_o[d]);
          end else begin
            x = sb[d].pop_front();
            chk("write_cycle", d, 64'(cyc), 64'(x.cyc));
            chk("out_addr", d, 64'(addr_o[d]), 64'(x.e.addr));
            chk("out_data", d, 64'(data_o[d]), 64'(x.e.data));
            chk("out_float", d, 64'(fl_o[d]), 64'(x.e.fl));
            chk("out_channel", d, 64'(ch_o[d]), 64'(x.ch));
            last[d]    = x.e;
            last_ch[d] = x.ch;
          end
        end else begin
          if (sb[d].size() > 0 && sb[d][0].cyc <= cyc) begin
            x = sb[d].pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write dut%0d cycle %0d: got out_enable 0 expected write ch %0d addr %0h",
                     d, cyc, x.ch, x.e.addr);
          end
          chk("hold_addr", d, 64'(addr_o[d]), 64'(last[d].addr));
          chk("hold_data", d, 64'(data_o[d]), 64'(last[d].data));
          chk("hold_float", d, 64'(fl_o[d]), 64'(last[d].fl));
          chk("hold_channel", d, 64'(ch_o[d]), 64'(last_ch[d]));
        end
      end
    end
  end

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] dt, input logic f);
    in_enable[i]       = 1'b1;
    in_addr[i*AW +: AW] = a;
    in_data[i*DW +: DW] = dt;
    in_float[i]        = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_enable = '0;
    in_float  = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < CH; i++) ch_out[d][i] = 0;
  endtask

  initial begin
    reset     = 1'b1;
    in_enable = '0;
    in_addr   = '0;
    in_data   = '0;
    in_float  = '0;
    step();
    step();
    reset = 1'b0;
    idle(2);

    // Single write on channel 0.
    set_ch(0, 5'd3, 32'h1234_5678, 1'b0);
    step();
    idle(3);

    // Both channels requesting together for three cycles.
    for (int c = 0; c < 3; c++) begin
      set_ch(0, 5'd1, $urandom, 1'b0);
      set_ch(1, 5'd2, $urandom, 1'b0);
      step();
    end
    idle(8);

    // Channel 0 streaming, channel 1 once at the start.
    for (int c = 0; c < 8; c++) begin
      set_ch(0, 5'(c + 4), $urandom, 1'b0);
      if (c == 0) set_ch(1, 5'd9, 32'hCAFE_0001, 1'b0);
      step();
    end
    idle(12);

    // Overflow of channel 1 while channel 0 holds priority.
    clear_counts();
    for (int c = 0; c < 8; c++) begin
      set_ch(0, 5'd7, $urandom, 1'b0);
      if (c < 5) set_ch(1, 5'(c + 10), $urandom, 1'b0);
      step();
      if (c == 3) chk("full_after_4th", 1, 64'(full_o[1][1]), 64'd1);
      if (c == 4) begin
        chk("ovf_after_5th", 1, 64'(ovf_o[1][1]), 64'd1);
        chk("full_after_5th", 1, 64'(full_o[1][1]), 64'd1);
      end
    end
    idle(12);
    chk("ch1_drained_count", 1, 64'(ch_out[1][1]), 64'd4);
    chk("ch0_drained_count", 1, 64'(ch_out[1][0]), 64'd8);

    // Integer r0 is discarded, float r0 is forwarded.
    set_ch(2, 5'd0, 32'hDEAD_BEEF, 1'b0);
    step();
    idle(3);
    set_ch(2, 5'd0, 32'h0F0F_0F0F, 1'b1);
    step();
    idle(3);

    // Reset with channel 1 loaded and overflowed; requests in the reset cycle are ignored.
    for (int c = 0; c < 6; c++) begin
      set_ch(0, 5'd6, $urandom, 1'b0);
      set_ch(1, 5'd12, $urandom, 1'b0);
      step();
    end
    chk("ovf_before_reset", 1, 64'(ovf_o[1][1]), 64'd1);
    reset = 1'b1;
    set_ch(1, 5'd13, 32'h5555_AAAA, 1'b0);
    step();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("en_after_reset", d, 64'(en_o[d]), 64'd0);
      chk("full_after_reset", d, 64'(full_o[d]), 64'd0);
      chk("ovf_after_reset", d, 64'(ovf_o[d]), 64'd0);
    end
    idle(6);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 99) < 40) begin
          set_ch(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, 1'($urandom_range(0, 1)));
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
      reset = 1'b0;
    end
    idle(3 * CH * DEPTH + 4);

    for (int d = 0; d < 2; d++) chk("scoreboard_empty", d, 64'(sb[d].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
